// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter for the shared SoC bus, with a bounded burst per owner.
// state | meaning: IDLE = no owner | OWN0 = CPU (M0) owns bus | OWN1 = M1 owns bus
module bus_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              ACLK,
    input  logic              RESET,
    input  logic              M0_REQ,
    input  logic [ADDR_W-1:0] M0_ADDR,
    input  logic              M0_WE,
    input  logic [DATA_W-1:0] M0_WDATA,
    output logic              M0_GNT,
    output logic              M0_RVALID,
    output logic [DATA_W-1:0] M0_RDATA,
    input  logic              M1_REQ,
    input  logic [ADDR_W-1:0] M1_ADDR,
    input  logic              M1_WE,
    input  logic [DATA_W-1:0] M1_WDATA,
    output logic              M1_GNT,
    output logic              M1_RVALID,
    output logic [DATA_W-1:0] M1_RDATA,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] DATA_O,
    output logic              WRSTB,
    output logic              RDSTB,
    input  logic [DATA_W-1:0] DATA_I
);

    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_rd_pend;
    logic             r_rd_own;

    logic w_own0;
    logic w_own1;
    logic w_req_oth;
    logic w_xfer;
    logic w_we;

    assign w_own0    = (r_state == S_OWN0);
    assign w_own1    = (r_state == S_OWN1);
    assign w_req_oth = w_own1 ? M0_REQ : M1_REQ;
    assign w_xfer    = (w_own0 & M0_REQ) | (w_own1 & M1_REQ);
    assign w_we      = w_own1 ? M1_WE : M0_WE;

    assign M0_GNT = w_own0 & M0_REQ;
    assign M1_GNT = w_own1 & M1_REQ;
    assign ADDR   = w_xfer ? (w_own1 ? M1_ADDR : M0_ADDR) : '0;
    assign DATA_O = w_xfer ? (w_own1 ? M1_WDATA : M0_WDATA) : '0;
    assign WRSTB  = w_xfer & w_we;
    assign RDSTB  = w_xfer & ~w_we;

    // RVALID is masked while RESET is high so an aborted read never reports data.
    assign M0_RVALID = r_rd_pend & ~r_rd_own & ~RESET;
    assign M1_RVALID = r_rd_pend & r_rd_own & ~RESET;
    assign M0_RDATA  = DATA_I;
    assign M1_RDATA  = DATA_I;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (M0_REQ && M1_REQ) begin
                    w_state_nxt = r_last ? S_OWN0 : S_OWN1;
                    w_last_nxt  = ~r_last;
                end else if (M0_REQ) begin
                    w_state_nxt = S_OWN0;
                    w_last_nxt  = 1'b0;
                end else if (M1_REQ) begin
                    w_state_nxt = S_OWN1;
                    w_last_nxt  = 1'b1;
                end
            end
            S_OWN0, S_OWN1: begin
                if (!w_xfer) begin
                    w_cnt_nxt = '0;
                    if (w_req_oth) begin
                        w_state_nxt = w_own1 ? S_OWN0 : S_OWN1;
                        w_last_nxt  = w_own0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_req_oth && (r_cnt == CNT_LAST)) begin
                    // burst exhausted: hand over on the same edge, no bubble
                    w_state_nxt = w_own1 ? S_OWN0 : S_OWN1;
                    w_last_nxt  = w_own0;
                    w_cnt_nxt   = '0;
                end else if (r_cnt != CNT_LAST) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_rd_pend <= 1'b0;
            r_rd_own  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rd_pend <= w_xfer & ~w_we;
            if (w_xfer && !w_we) begin
                r_rd_own <= w_own1;
            end
        end
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the single memory-mapped SoC bus (ADDR / DATA_O / WRSTB / RDSTB / DATA_I) shared by all slaves: data memory, VGA, GPIO, LCD and RS232.
- M0 is the CPU; M1 is a second bus master, e.g. a UART boot loader or DMA engine.
- The arbiter grants one master at a time, round-robin, with a bounded burst length.
- It drives the shared bus from the owner and returns slave read data to the master that issued the read.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_BURST, 8, max consecutive transfers by one owner while the other master waits (≥1)

Ports:
- ACLK  in  1  clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- M0_REQ / M1_REQ  in  1  transfer request; ADDR/WE/WDATA must be held stable while high
- M0_ADDR / M1_ADDR  in  ADDR_W  transfer address
- M0_WE / M1_WE  in  1  1 = write, 0 = read
- M0_WDATA / M1_WDATA  in  DATA_W  write data
- M0_GNT / M1_GNT  out  1  transfer accepted this cycle
- M0_RVALID / M1_RVALID  out  1  read data valid on Mx_RDATA
- M0_RDATA / M1_RDATA  out  DATA_W  read data (both equal DATA_I)
- ADDR  out  ADDR_W  bus address
- DATA_O  out  DATA_W  bus write data
- WRSTB  out  1  bus write strobe
- RDSTB  out  1  bus read strobe
- DATA_I  in  DATA_W  slave read data; valid the cycle after RDSTB

## Operation
- Registered state: state ∈ {IDLE, OWN0, OWN1}; last (last owner); cnt (0..MAX_BURST-1); rd_pend; rd_own.
- Transfer: in OWNx with Mx_REQ=1:
  - Mx_GNT=1; ADDR=Mx_ADDR; DATA_O=Mx_WDATA.
  - WRSTB=Mx_WE; RDSTB=~Mx_WE.
  - All of these are combinational from state and inputs.
- Otherwise GNT, ADDR, DATA_O, WRSTB and RDSTB are 0.
- IDLE:
  - If exactly one REQ is high, go to that OWNx.
  - If both are high, go to the master ≠ last.
  - No transfer occurs in IDLE.
- OWNx, with y the other master:
  - Mx_REQ=0: next state OWNy if My_REQ, else IDLE. No transfer this cycle.
  - Transfer with My_REQ=1 and cnt==MAX_BURST-1: next state OWNy, with no bubble.
  - Any other transfer: stay in OWNx; cnt increments, saturating at MAX_BURST-1.
- On every ownership change: cnt←0 and last←new owner.
  - Entering OWNx from IDLE also sets last←x.
- Read return:
  - On a read transfer: rd_pend←1 and rd_own←x. Otherwise rd_pend←0.
  - Mx_RVALID = rd_pend && rd_own==x.
  - Mx_RDATA = DATA_I, combinational, for both masters.
- Masters may issue back-to-back reads; each RVALID corresponds to the read granted the previous cycle.

## Timing
- Reset values:
  - state=IDLE, last=1 (M0 wins the first tie), cnt=0, rd_pend=0.
  - All outputs 0, except Mx_RDATA, which follows DATA_I.
- Grant latency:
  - REQ rising in IDLE at cycle t → GNT at t+1.
  - While owned, GNT arrives in the same cycle as REQ.
- Throughput:
  - One transfer per cycle for the owner.
  - Forced handoff: zero bubbles.
  - Voluntary release (REQ drop) with the other master waiting: one bubble cycle.
- Read latency: RDSTB at t → Mx_RVALID and valid Mx_RDATA at t+1.
- Simultaneous REQ from IDLE: round-robin by last.
- MAX_BURST=1 alternates ownership every transfer when both masters request.
- RESET mid-operation:
  - Next cycle: IDLE, all strobes 0.
  - A pending read's RVALID is suppressed (rd_pend cleared).
  - The master must reissue.
- Master must not drop REQ in a cycle where it has GNT before that cycle's edge; a drop is sampled as "no transfer".

## Test plan
- Reset, then M0_REQ=1 write to 0x0000_0010 with data 0xDEADBEEF:
  - Cycle 1 after REQ: M0_GNT=1, WRSTB=1, ADDR=0x10, DATA_O=0xDEADBEEF.
  - RDSTB=0; M1_GNT=0 throughout.
- M1 read of 0x0000_0040 with DATA_I=0x12345678 one cycle later:
  - RDSTB=1 in the grant cycle.
  - Next cycle: M1_RVALID=1, M1_RDATA=0x12345678, M0_RVALID=0.
- Both REQ rise together after reset, MAX_BURST=8, continuous:
  - M0 gets grants 1–8, then M1 gets 8, alternating with no idle cycle between.
  - Strobe count equals cycles minus 1.
- M0 owns and drops REQ while M1_REQ=1:
  - Exactly one cycle with no strobes, then M1_GNT=1.
  - cnt restarts, so M1 gets 8 grants before M0 regains ownership.
- RESET asserted the cycle after an M0 read grant:
  - M0_RVALID stays 0.
  - Next cycle: all outputs 0, state IDLE.
  - Simultaneous REQs afterwards grant M0 first.
